// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: periodic START_ADC/EOC sequencing of the I/V ADC pair with a valid/ack handoff and sticky error flags.
// Optional build macro ADC_OVERSAMPLE_EN: four conversions per tick, averaged (truncating) into I_OUT/V_OUT.
module adc_sample_sequencer #(
  parameter int ADC_W         = 12,
  parameter int SAMPLE_PERIOD = 2000,
  parameter int EOC_TIMEOUT   = 255,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             CLR_ERR,
  input  logic             EOC,
  input  logic [ADC_W-1:0] I_ADC,
  input  logic [ADC_W-1:0] V_ADC,
  input  logic             SAMPLE_ACK,
  output logic             START_ADC,
  output logic [ADC_W-1:0] I_OUT,
  output logic [ADC_W-1:0] V_OUT,
  output logic             SAMPLE_VALID,
  output logic [CNT_W-1:0] SAMPLE_CNT,
  output logic             TIMEOUT_ERR,
  output logic             OVERRUN,
  output logic             BUSY
);
  localparam int PER_W = 16;
  localparam int TO_W  = 16;

  typedef enum logic [2:0] {IDLE, START, WAIT_EOC, HANDOFF, WAIT_TICK} state_t;

  state_t             state_reg, state_next;
  logic [PER_W-1:0]   period_reg;
  logic [TO_W-1:0]    tcnt_reg;
  logic [ADC_W-1:0]   i_out_reg, v_out_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               timeout_reg, overrun_reg;
  logic               tick;
  logic               capture, take_ack, timeout_evt, overrun_evt;
  logic               last_conv;
  logic [ADC_W-1:0]   capture_i, capture_v;

  // The period counter sits at 0 while disabled, so enabling yields an immediate tick.
  assign tick = ENABLE && (period_reg == '0);

`ifdef ADC_OVERSAMPLE_EN
  logic [1:0]       conv_reg;
  logic [ADC_W+1:0] i_sum_reg, v_sum_reg, i_sum_next, v_sum_next;

  assign last_conv  = (conv_reg == 2'd3);
  assign i_sum_next = ((conv_reg == 2'd0) ? {(ADC_W+2){1'b0}} : i_sum_reg) + {2'b00, I_ADC};
  assign v_sum_next = ((conv_reg == 2'd0) ? {(ADC_W+2){1'b0}} : v_sum_reg) + {2'b00, V_ADC};
  assign capture_i  = i_sum_next[ADC_W+1:2];
  assign capture_v  = v_sum_next[ADC_W+1:2];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      conv_reg  <= '0;
      i_sum_reg <= '0;
      v_sum_reg <= '0;
    end else begin
      if (capture) begin
        i_sum_reg <= i_sum_next;
        v_sum_reg <= v_sum_next;
      end
      // Any exit from the conversion loop (done, timeout, disable) restarts the set.
      if (state_next == START || state_next == WAIT_EOC) begin
        if (capture) conv_reg <= conv_reg + 2'd1;
      end else begin
        conv_reg <= '0;
      end
    end
  end
`else
  assign last_conv = 1'b1;
  assign capture_i = I_ADC;
  assign capture_v = V_ADC;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    capture     = 1'b0;
    take_ack    = 1'b0;
    timeout_evt = 1'b0;
    overrun_evt = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ENABLE) state_next = START;
      end
      START: begin
        state_next = ENABLE ? WAIT_EOC : IDLE;
      end
      WAIT_EOC: begin
        if (!ENABLE) begin
          state_next = IDLE;
        end else if (EOC) begin
          capture    = 1'b1;
          state_next = last_conv ? HANDOFF : START;
        end else if (tcnt_reg == TO_W'(EOC_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_next  = WAIT_TICK;
        end
      end
      HANDOFF: begin
        if (SAMPLE_ACK) begin
          take_ack = 1'b1;
          if (!ENABLE)   state_next = IDLE;
          else if (tick) state_next = START;
          else           state_next = WAIT_TICK;
        end else if (tick) begin
          overrun_evt = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (!ENABLE)   state_next = IDLE;
        else if (tick) state_next = START;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      period_reg  <= '0;
      tcnt_reg    <= '0;
      i_out_reg   <= '0;
      v_out_reg   <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (!ENABLE || period_reg == PER_W'(SAMPLE_PERIOD - 1)) period_reg <= '0;
      else                                                     period_reg <= period_reg + PER_W'(1);

      // tcnt counts cycles since the START_ADC cycle.
      if (state_reg == START)         tcnt_reg <= TO_W'(1);
      else if (state_reg == WAIT_EOC) tcnt_reg <= tcnt_reg + TO_W'(1);

      if (capture && last_conv) begin
        i_out_reg <= capture_i;
        v_out_reg <= capture_v;
      end

      if (take_ack) cnt_reg <= cnt_reg + CNT_W'(1);

      // A new error event outranks a simultaneous clear.
      if (timeout_evt)  timeout_reg <= 1'b1;
      else if (CLR_ERR) timeout_reg <= 1'b0;

      if (overrun_evt)  overrun_reg <= 1'b1;
      else if (CLR_ERR) overrun_reg <= 1'b0;
    end
  end

  assign START_ADC    = (state_reg == START);
  assign SAMPLE_VALID = (state_reg == HANDOFF);
  assign BUSY         = (state_reg != IDLE);
  assign I_OUT        = i_out_reg;
  assign V_OUT        = v_out_reg;
  assign SAMPLE_CNT   = cnt_reg;
  assign TIMEOUT_ERR  = timeout_reg;
  assign OVERRUN      = overrun_reg;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer (default build): ADC model feeds a scoreboard queue of expected I/V samples.
module tb_adc_sample_sequencer;
  localparam int ADC_W = 12;
  localparam int CNT_W = 16;

  logic             CLK, RST, ENABLE, CLR_ERR, SAMPLE_ACK;
  logic             EOC;
  logic [ADC_W-1:0] I_ADC, V_ADC;
  logic             START_ADC, SAMPLE_VALID, TIMEOUT_ERR, OVERRUN, BUSY;
  logic [ADC_W-1:0] I_OUT, V_OUT;
  logic [CNT_W-1:0] SAMPLE_CNT;

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               last_s;
  logic [CNT_W-1:0] cnt_exp;
  logic [2*ADC_W-1:0] exp_q[$];
  logic [ADC_W-1:0] adc_i, adc_v;
  bit               adc_on;

  adc_sample_sequencer dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .CLR_ERR(CLR_ERR), .EOC(EOC),
    .I_ADC(I_ADC), .V_ADC(V_ADC), .SAMPLE_ACK(SAMPLE_ACK),
    .START_ADC(START_ADC), .I_OUT(I_OUT), .V_OUT(V_OUT), .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_CNT(SAMPLE_CNT), .TIMEOUT_ERR(TIMEOUT_ERR), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ADC model: EOC for one cycle, 10 cycles after a START_ADC pulse; data is junk outside EOC.
  initial begin
    EOC = 1'b0; I_ADC = '0; V_ADC = '0;
    forever begin
      @(negedge CLK);
      if (START_ADC === 1'b1 && adc_on) begin
        repeat (10) @(negedge CLK);
        EOC = 1'b1; I_ADC = adc_i; V_ADC = adc_v;
        exp_q.push_back({adc_i, adc_v});
        @(negedge CLK);
        EOC = 1'b0;
        I_ADC = 12'($urandom_range(0, 4095));
        V_ADC = 12'($urandom_range(0, 4095));
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*ADC_W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic new_values();
    adc_i = 12'($urandom_range(1, 4095));
    adc_v = 12'($urandom_range(1, 4095));
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      @(negedge CLK);
      if (START_ADC === 1'b1) at = cyc;
    end
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      @(negedge CLK);
      if (SAMPLE_VALID === 1'b1) at = cyc;
    end
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic test_reset();
    checks++;
    if ({START_ADC, SAMPLE_VALID, TIMEOUT_ERR, OVERRUN, BUSY} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {START_ADC, SAMPLE_VALID, TIMEOUT_ERR, OVERRUN, BUSY});
    end
    checks++;
    if ({I_OUT, V_OUT} !== 24'h0) begin
      errors++; $display("FAIL reset_data: got I=%h V=%h want 0", I_OUT, V_OUT);
    end
    checks++;
    if (SAMPLE_CNT !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", SAMPLE_CNT);
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || START_ADC !== 1'b0) begin
      errors++; $display("FAIL idle_disabled: got BUSY=%b START=%b want 0 0", BUSY, START_ADC);
    end
  endtask

  task automatic test_basic();
    int t0, s, v;
    logic [2*ADC_W-1:0] e;
    adc_i = 12'h3A5; adc_v = 12'h7FF;
    ENABLE = 1'b1; t0 = cyc;
    wait_start(10, s);
    checks++;
    if (s !== t0 + 1) begin errors++; $display("FAIL basic_first_start: got cycle %0d want %0d", s, t0 + 1); end
    @(negedge CLK);
    checks++;
    if (START_ADC !== 1'b0) begin errors++; $display("FAIL basic_start_width: got START=%b want 0", START_ADC); end
    wait_valid(50, v);
    checks++;
    if (v !== s + 11) begin errors++; $display("FAIL basic_valid_latency: got cycle %0d want %0d", v, s + 11); end
    e = pop_exp();
    checks++;
    if ({I_OUT, V_OUT} !== e || e !== {12'h3A5, 12'h7FF}) begin
      errors++; $display("FAIL basic_data: got I=%h V=%h want I=3a5 V=7ff", I_OUT, V_OUT);
    end
    goto_cycle(v + 5);
    checks++;
    if (SAMPLE_VALID !== 1'b1 || {I_OUT, V_OUT} !== e) begin
      errors++; $display("FAIL basic_hold: got VALID=%b I=%h V=%h want 1 %h", SAMPLE_VALID, I_OUT, V_OUT, e);
    end
    SAMPLE_ACK = 1'b1; @(negedge CLK); SAMPLE_ACK = 1'b0; cnt_exp++;
    checks++;
    if (SAMPLE_VALID !== 1'b0 || SAMPLE_CNT !== cnt_exp) begin
      errors++; $display("FAIL basic_ack: got VALID=%b CNT=%0d want 0 %0d", SAMPLE_VALID, SAMPLE_CNT, cnt_exp);
    end
    wait_start(2100, v);
    checks++;
    if (v !== s + 2000) begin errors++; $display("FAIL basic_period: got cycle %0d want %0d", v, s + 2000); end
    last_s = v; new_values();
  endtask

  task automatic test_back_to_back();
    int s, v, d;
    logic [2*ADC_W-1:0] e;
    for (int n = 0; n < 3; n++) begin
      s = last_s;
      wait_valid(50, v);
      checks++;
      if (v !== s + 11) begin errors++; $display("FAIL b2b_latency[%0d]: got cycle %0d want %0d", n, v, s + 11); end
      e = pop_exp();
      checks++;
      if ({I_OUT, V_OUT} !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", n, {I_OUT, V_OUT}, e); end
      d = $urandom_range(0, 30);
      goto_cycle(v + d);
      SAMPLE_ACK = 1'b1; @(negedge CLK); SAMPLE_ACK = 1'b0; cnt_exp++;
      checks++;
      if (SAMPLE_VALID !== 1'b0 || SAMPLE_CNT !== cnt_exp) begin
        errors++; $display("FAIL b2b_ack[%0d]: got VALID=%b CNT=%0d want 0 %0d", n, SAMPLE_VALID, SAMPLE_CNT, cnt_exp);
      end
      if (n == 2) adc_on = 1'b0;
      wait_start(2100, v);
      checks++;
      if (v !== s + 2000) begin errors++; $display("FAIL b2b_period[%0d]: got cycle %0d want %0d", n, v, s + 2000); end
      last_s = v; new_values();
    end
  endtask

  task automatic test_timeout();
    int s, s2, v, first;
    bit saw_valid;
    s = last_s; first = -1; saw_valid = 1'b0;
    for (int k = 0; k < 400 && first < 0; k++) begin
      @(negedge CLK);
      if (SAMPLE_VALID !== 1'b0) saw_valid = 1'b1;
      if (TIMEOUT_ERR === 1'b1) first = cyc;
    end
    checks++;
    if (first !== s + 255) begin errors++; $display("FAIL timeout_time: got cycle %0d want %0d", first, s + 255); end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL timeout_no_sample: got VALID=1 want 0"); end
    wait_start(2100, v);
    checks++;
    if (v !== s + 2000) begin errors++; $display("FAIL timeout_period: got cycle %0d want %0d", v, s + 2000); end
    s2 = v;
    goto_cycle(s2 + 254);
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
    checks++;
    if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL timeout_err_wins: got %b want 1", TIMEOUT_ERR); end
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
    checks++;
    if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", TIMEOUT_ERR); end
    adc_on = 1'b1;
    wait_start(2100, v);
    checks++;
    if (v !== s2 + 2000) begin errors++; $display("FAIL timeout_period2: got cycle %0d want %0d", v, s2 + 2000); end
    last_s = v; new_values();
  endtask

  task automatic test_overrun();
    int s, v;
    logic [2*ADC_W-1:0] e;
    s = last_s;
    wait_valid(50, v);
    e = pop_exp();
    checks++;
    if ({I_OUT, V_OUT} !== e) begin errors++; $display("FAIL overrun_data: got %h want %h", {I_OUT, V_OUT}, e); end
    goto_cycle(s + 1999);
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b want 0", OVERRUN); end
    @(negedge CLK);
    checks++;
    if (OVERRUN !== 1'b1 || START_ADC !== 1'b0 || SAMPLE_VALID !== 1'b1) begin
      errors++; $display("FAIL overrun_tick: got OVR=%b START=%b VALID=%b want 1 0 1", OVERRUN, START_ADC, SAMPLE_VALID);
    end
    goto_cycle(s + 2500);
    checks++;
    if ({I_OUT, V_OUT} !== e) begin errors++; $display("FAIL overrun_hold: got %h want %h", {I_OUT, V_OUT}, e); end
    SAMPLE_ACK = 1'b1; @(negedge CLK); SAMPLE_ACK = 1'b0; cnt_exp++;
    checks++;
    if (SAMPLE_VALID !== 1'b0 || SAMPLE_CNT !== cnt_exp) begin
      errors++; $display("FAIL overrun_ack: got VALID=%b CNT=%0d want 0 %0d", SAMPLE_VALID, SAMPLE_CNT, cnt_exp);
    end
    CLR_ERR = 1'b1; @(negedge CLK); CLR_ERR = 1'b0;
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", OVERRUN); end
    wait_start(2000, v);
    checks++;
    if (v !== s + 4000) begin errors++; $display("FAIL overrun_next_start: got cycle %0d want %0d", v, s + 4000); end
    last_s = v; new_values();
  endtask

  task automatic test_ack_on_tick();
    int s, v;
    logic [2*ADC_W-1:0] e;
    s = last_s;
    wait_valid(50, v);
    e = pop_exp();
    checks++;
    if ({I_OUT, V_OUT} !== e) begin errors++; $display("FAIL acktick_data: got %h want %h", {I_OUT, V_OUT}, e); end
    goto_cycle(s + 1999);
    SAMPLE_ACK = 1'b1; @(negedge CLK); SAMPLE_ACK = 1'b0; cnt_exp++;
    checks++;
    if (START_ADC !== 1'b1 || OVERRUN !== 1'b0 || SAMPLE_VALID !== 1'b0) begin
      errors++; $display("FAIL acktick_state: got START=%b OVR=%b VALID=%b want 1 0 0", START_ADC, OVERRUN, SAMPLE_VALID);
    end
    checks++;
    if (SAMPLE_CNT !== cnt_exp) begin errors++; $display("FAIL acktick_cnt: got %0d want %0d", SAMPLE_CNT, cnt_exp); end
    last_s = cyc; new_values();
  endtask

  task automatic test_reset_mid_handshake();
    int v;
    logic [2*ADC_W-1:0] e;
    wait_valid(50, v);
    e = pop_exp();
    checks++;
    if ({I_OUT, V_OUT} !== e) begin errors++; $display("FAIL rsths_data: got %h want %h", {I_OUT, V_OUT}, e); end
    @(negedge CLK); @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    checks++;
    if ({SAMPLE_VALID, BUSY, START_ADC} !== 3'b0 || {I_OUT, V_OUT} !== 24'h0 || SAMPLE_CNT !== 16'h0) begin
      errors++; $display("FAIL rsths_async: got VALID=%b BUSY=%b I=%h V=%h CNT=%0d want all 0",
                         SAMPLE_VALID, BUSY, I_OUT, V_OUT, SAMPLE_CNT);
    end
    cnt_exp = '0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_enable_drop();
    int r, s;
    bit saw_valid, saw_start;
    r = cyc; saw_valid = 1'b0; saw_start = 1'b0;
    wait_start(10, s);
    checks++;
    if (s !== r + 1) begin errors++; $display("FAIL drop_restart: got cycle %0d want %0d", s, r + 1); end
    goto_cycle(s + 3);
    ENABLE = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL drop_idle: got BUSY=%b want 0", BUSY); end
    for (int k = 5; k <= 30; k++) begin
      @(negedge CLK);
      SAMPLE_ACK = (k == 12);
      if (SAMPLE_VALID !== 1'b0) saw_valid = 1'b1;
      if (START_ADC !== 1'b0) saw_start = 1'b1;
    end
    SAMPLE_ACK = 1'b0;
    checks++;
    if (saw_valid || saw_start || BUSY !== 1'b0) begin
      errors++; $display("FAIL drop_ignore_eoc: got valid_seen=%b start_seen=%b BUSY=%b want 0 0 0", saw_valid, saw_start, BUSY);
    end
    checks++;
    if (SAMPLE_CNT !== cnt_exp || TIMEOUT_ERR !== 1'b0 || OVERRUN !== 1'b0) begin
      errors++; $display("FAIL drop_counts: got CNT=%0d TO=%b OVR=%b want %0d 0 0", SAMPLE_CNT, TIMEOUT_ERR, OVERRUN, cnt_exp);
    end
    exp_q.delete();
  endtask

  initial begin
    RST = 1'b0; ENABLE = 1'b0; CLR_ERR = 1'b0; SAMPLE_ACK = 1'b0;
    adc_on = 1'b1; adc_i = 12'h3A5; adc_v = 12'h7FF; cnt_exp = '0;
    repeat (3) @(negedge CLK);
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_ack_on_tick();
    test_reset_mid_handshake();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
- Sequences the external 12-bit current/voltage ADC pair that feeds the estimator core.
- Issues periodic START_ADC pulses and waits for EOC, then captures I and V.
- Presents each captured sample to the estimator through a valid/ack handshake.
- Detects ADC timeouts and estimator overruns, and reports both as sticky flags.

Parameters:
- ADC_W, 12: width of the I and V sample buses.
- SAMPLE_PERIOD, 2000: clock cycles between successive conversion starts; legal range 16..65535.
- EOC_TIMEOUT, 255: maximum cycles from START_ADC to EOC before a timeout is declared.
- CNT_W, 16: width of the sample counter.

Ports:
- CLK, in, 1: system clock; all logic on the rising edge.
- RST, in, 1: reset; asynchronous, active-low.
- ENABLE, in, 1: runs the sequencer while high.
- CLR_ERR, in, 1: one-cycle pulse that clears the sticky flags.
- EOC, in, 1: ADC end of conversion; level-sampled.
- I_ADC, in, ADC_W: ADC current result; valid while EOC is high.
- V_ADC, in, ADC_W: ADC voltage result; valid while EOC is high.
- SAMPLE_ACK, in, 1: estimator has consumed the sample (driven from the estimator ACK).
- START_ADC, out, 1: one-cycle conversion start pulse.
- I_OUT, out, ADC_W: held current sample.
- V_OUT, out, ADC_W: held voltage sample.
- SAMPLE_VALID, out, 1: I_OUT/V_OUT are valid for the estimator.
- SAMPLE_CNT, out, CNT_W: count of samples delivered (acknowledged); wraps.
- TIMEOUT_ERR, out, 1: sticky; EOC did not arrive in time.
- OVERRUN, out, 1: sticky; a period elapsed while a sample was still unacknowledged.
- BUSY, out, 1: state is not IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE; period counter is cleared.
  - All outputs are 0: START_ADC, SAMPLE_VALID, I_OUT, V_OUT, SAMPLE_CNT, TIMEOUT_ERR, OVERRUN, BUSY.
  - Reset mid-conversion or mid-handshake abandons the sample with no error flagged.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while ENABLE is high; held at 0 while ENABLE is low.
  - A "tick" occurs at count 0.
- States: IDLE, START, WAIT_EOC, HANDOFF, WAIT_TICK.
  - IDLE: on ENABLE=1, go to START in the next cycle; the counter starts at 0, so the first tick is immediate.
  - START: START_ADC=1 for exactly 1 cycle; clear the timeout counter; go to WAIT_EOC.
  - WAIT_EOC: if EOC=1, register I_ADC/V_ADC into I_OUT/V_OUT and go to HANDOFF, with SAMPLE_VALID=1 from the next cycle. Latency from the EOC edge to SAMPLE_VALID is 1 cycle. If the timeout counter reaches EOC_TIMEOUT with no EOC, set TIMEOUT_ERR and go to WAIT_TICK with no sample delivered.
  - HANDOFF: SAMPLE_VALID stays high and I_OUT/V_OUT stay stable until SAMPLE_ACK=1. In the ACK cycle: SAMPLE_VALID drops next cycle, SAMPLE_CNT increments (wraps at 2^CNT_W), then go to WAIT_TICK. If a tick occurs while in HANDOFF, set OVERRUN and skip that conversion; the sample is not replaced.
  - WAIT_TICK: on a tick go to START; if ENABLE=0, go to IDLE.
- ENABLE dropped:
  - In START or WAIT_EOC: go to IDLE immediately. A START_ADC already issued is not repeated, and EOC arriving later is ignored.
  - In HANDOFF: the handshake completes first, then the block goes to IDLE.
- SAMPLE_ACK outside HANDOFF is ignored.
- EOC outside WAIT_EOC is ignored; no flag is set.
- Simultaneous CLR_ERR and a new error event in the same cycle: the error wins and the flag stays 1.
- ACK and tick in the same cycle while in HANDOFF: the ACK is taken, OVERRUN is not set, and the next state is START.

Optional Feature:
- Macro: ADC_OVERSAMPLE_EN.
- Defined:
  - Each tick launches 4 back-to-back conversions (START, WAIT_EOC repeated); the next START follows the previous EOC by 1 cycle.
  - I and V are accumulated into ADC_W+2-bit sums; I_OUT/V_OUT = sum[ADC_W+1:2], which truncates.
  - A timeout on any of the 4 conversions aborts the set, sets TIMEOUT_ERR, and delivers no sample.
- Undefined: one conversion per tick, as described above.

Test Plan:
- Basic sequence: RST low then high, ENABLE=1, ADC model returns EOC 10 cycles after START with I=0x3A5, V=0x7FF → START_ADC 1-cycle pulse; SAMPLE_VALID 1 cycle after EOC with I_OUT=0x3A5, V_OUT=0x7FF; ACK after 5 cycles → SAMPLE_CNT=1; next START exactly 2000 cycles after the first.
- Timeout: ADC model never raises EOC → TIMEOUT_ERR=1 at 255 cycles after START, SAMPLE_VALID stays 0, next START at 2000; CLR_ERR pulse → TIMEOUT_ERR=0.
- Overrun: withhold SAMPLE_ACK for 2500 cycles → OVERRUN=1 at the tick at cycle 2000, no START_ADC at that tick, I_OUT unchanged; after ACK, the next START is at cycle 4000.
- Reset mid-handshake: RST low during HANDOFF → SAMPLE_VALID, I_OUT and SAMPLE_CNT go to 0 asynchronously, before the next CLK edge.
- ENABLE drop: ENABLE=0 in WAIT_EOC → IDLE, a later EOC is ignored, BUSY=0, SAMPLE_CNT unchanged.
- ADC_OVERSAMPLE_EN build: 4 EOCs with I=100,101,102,104 → I_OUT=101 (407>>2), SAMPLE_CNT=1.
